bus_sequencer: RTL and testbench

- Parametrised successor to the micro-BESM external bus arbiter. It turns a 4-bit bus request code into timed strobe sequences on the busio port and the memory bus.
- Adds configurable strobe timing, memory-ready (ack) wait states, a timeout with error report, block-transfer bursts and a locked read-modify-write.
- Sits between the microinstruction control unit, which issues `request` and waits for `done`, and the busio registers / external memory.

---
 rtl/bus_pkg.sv | 67 ++++++
 rtl/bus_phase_timer.sv | 34 +++
 rtl/bus_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_bus_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and code classification for the bus sequencer.
package bus_pkg;

  typedef enum logic [3:0] {
    REQ_NONE = 4'd0,
    CCRD     = 4'd1,
    CCWR     = 4'd2,
    DCRD     = 4'd3,
    DCWR     = 4'd4,
    ILL5     = 4'd5,
    ILL6     = 4'd6,
    ILL7     = 4'd7,
    FETCH    = 4'd8,
    DRD      = 4'd9,
    DWR      = 4'd10,
    RDMWR    = 4'd11,
    BTRWR    = 4'd12,
    BTRRD    = 4'd13,
    BICLR    = 4'd14,
    BIRD     = 4'd15
  } req_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    XFER,
    GAP,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ARX_ADDR = 2'b00;
  localparam logic [1:0] ARX_DATA = 2'b01;
  localparam logic [1:0] ARX_NONE = 2'b11;

  typedef struct packed {
    logic [1:0] arx;
    logic       ecx;
    logic       wrx;
    logic       astb;
    logic       rd;
    logic       wr;
    logic       done;
    logic       err;
  } bus_out_t;

  function automatic logic is_read(input req_t code);
    return code inside {CCRD, DCRD, FETCH, DRD, BTRRD, BIRD};
  endfunction

  function automatic logic is_write(input req_t code);
    return code inside {CCWR, DCWR, DWR, BTRWR, BICLR};
  endfunction

  function automatic logic is_rmw(input req_t code);
    return code == RDMWR;
  endfunction

  function automatic logic is_burst(input req_t code);
    return code inside {BTRWR, BTRRD};
  endfunction

  function automatic logic is_illegal(input req_t code);
    return code inside {ILL5, ILL6, ILL7};
  endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable 8-bit phase counter. Counts down toward zero (terminal count at 0)
// or up from the loaded value (terminal count at lim_val); min_hit reports
// that the count has reached min_val.
module bus_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       up,
  input  logic [7:0] load_val,
  input  logic [7:0] min_val,
  input  logic [7:0] lim_val,
  output logic       min_hit,
  output logic       tc_hit
);

  logic [7:0] count;

  // Counter register: load has priority, otherwise saturating count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (up) begin
      if (count != 8'hff) count <= count + 8'd1;
    end else begin
      if (count != 8'd0) count <= count - 8'd1;
    end
  end

  assign min_hit = (count >= min_val);
  assign tc_hit  = up ? (count == lim_val) : (count == 8'd0);

endmodule

// File: rtl/bus_sequencer.sv
// Bus request sequencer: turns a 4-bit request code into timed strobes on the
// busio port and the memory bus, with ack wait states, timeout, bursts and RMW.
//
//   state | meaning
//   IDLE  | waiting for a non-zero request, outputs idle
//   ADDR  | address on busio, astb asserted for T_ASTB cycles
//   XFER  | data phase, rd or wr held until an honoured ack or timeout
//   GAP   | one dead cycle between burst words / RMW halves, astb held
//   DONE  | done=1 until request returns to 0
//   ERR   | done=1 err=1 until request returns to 0
module bus_sequencer
  import bus_pkg::*;
#(
  parameter int T_ASTB    = 1,
  parameter int T_XFER    = 2,
  parameter int TIMEOUT   = 127,
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] request,
  input  logic       ack,
  output logic [1:0] arx,
  output logic       ecx,
  output logic       wrx,
  output logic       astb,
  output logic       rd,
  output logic       wr,
  output logic       done,
  output logic       err,
  output logic [3:0] word_idx
);

  localparam logic [7:0] ASTB_LAST = 8'(T_ASTB - 1);
  localparam logic [7:0] XFER_MIN  = 8'(T_XFER - 1);
  localparam logic [7:0] XFER_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] LAST_IDX  = 4'(BURST_LEN - 1);

  state_t   state, state_nx;
  req_t     op, op_nx;
  logic     rmw_wr, rmw_wr_nx;
  logic [3:0] idx_nx;
  bus_out_t out_nx;
  logic     read_half;

  logic       tmr_load;
  logic       tmr_up;
  logic [7:0] tmr_load_val;
  logic       min_hit;
  logic       tc_hit;

  // ADDR counts down from T_ASTB-1; XFER counts up from 0 so the same count
  // serves both the ack-honour threshold and the timeout.
  assign tmr_up       = (state == XFER);
  assign tmr_load     = (state_nx != state) && (state_nx == ADDR || state_nx == XFER);
  assign tmr_load_val = (state_nx == ADDR) ? ASTB_LAST : 8'd0;

  bus_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .up       (tmr_up),
    .load_val (tmr_load_val),
    .min_val  (XFER_MIN),
    .lim_val  (XFER_LAST),
    .min_hit  (min_hit),
    .tc_hit   (tc_hit)
  );

  // State register; outputs are registered from the next-state decode so
  // they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op       <= REQ_NONE;
      rmw_wr   <= 1'b0;
      word_idx <= 4'd0;
      arx      <= ARX_NONE;
      ecx      <= 1'b0;
      wrx      <= 1'b0;
      astb     <= 1'b0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      op       <= op_nx;
      rmw_wr   <= rmw_wr_nx;
      word_idx <= idx_nx;
      arx      <= out_nx.arx;
      ecx      <= out_nx.ecx;
      wrx      <= out_nx.wrx;
      astb     <= out_nx.astb;
      rd       <= out_nx.rd;
      wr       <= out_nx.wr;
      done     <= out_nx.done;
      err      <= out_nx.err;
    end
  end

  // Next-state logic; a zero request while busy aborts (or releases DONE/ERR).
  always_comb begin
    state_nx  = state;
    op_nx     = op;
    rmw_wr_nx = rmw_wr;
    idx_nx    = word_idx;
    if (state == IDLE) begin
      if (request != 4'd0) begin
        op_nx     = req_t'(request);
        rmw_wr_nx = 1'b0;
        idx_nx    = 4'd0;
        state_nx  = is_illegal(req_t'(request)) ? ERR : ADDR;
      end
    end else if (request == 4'd0) begin
      state_nx  = IDLE;
      rmw_wr_nx = 1'b0;
      idx_nx    = 4'd0;
    end else begin
      case (state)
        ADDR: begin
          if (tc_hit) state_nx = XFER;
        end
        XFER: begin
          if (ack && min_hit) begin
            if (is_burst(op) && word_idx < LAST_IDX) begin
              idx_nx   = word_idx + 4'd1;
              state_nx = GAP;
            end else if (is_rmw(op) && !rmw_wr) begin
              rmw_wr_nx = 1'b1;
              state_nx  = GAP;
            end else begin
              state_nx = DONE;
            end
          end else if (tc_hit) begin
            state_nx = ERR;
          end
        end
        GAP:     state_nx = XFER;
        default: state_nx = state;
      endcase
    end
  end

  // Output decode for the state being entered.
  always_comb begin
    out_nx.arx  = ARX_NONE;
    out_nx.ecx  = 1'b0;
    out_nx.wrx  = 1'b0;
    out_nx.astb = 1'b0;
    out_nx.rd   = 1'b0;
    out_nx.wr   = 1'b0;
    out_nx.done = 1'b0;
    out_nx.err  = 1'b0;
    read_half   = is_rmw(op_nx) ? !rmw_wr_nx : is_read(op_nx);
    case (state_nx)
      ADDR: begin
        out_nx.arx  = ARX_ADDR;
        out_nx.ecx  = 1'b1;
        out_nx.astb = 1'b1;
      end
      XFER: begin
        out_nx.arx  = ARX_DATA;
        out_nx.ecx  = 1'b1;
        out_nx.rd   = read_half;
        out_nx.wrx  = read_half;
        out_nx.wr   = !read_half;
        out_nx.astb = is_rmw(op_nx) || is_burst(op_nx);
      end
      GAP: begin
        out_nx.astb = 1'b1;
      end
      DONE: begin
        out_nx.done = 1'b1;
      end
      ERR: begin
        out_nx.done = 1'b1;
        out_nx.err  = 1'b1;
      end
      default: begin
        out_nx.arx = ARX_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: the stimulus side predicts each
// transaction's strobe phases from the code rules and the ack delays it
// drives; a monitor rebuilds the observed phases and compares on done.
module tb_bus_sequencer;

  localparam int TA = 2;
  localparam int TX = 2;
  localparam int TO = 10;
  localparam int BL = 4;
  localparam logic [12:0] IDLE_V = {2'b11, 11'd0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] request = 4'd0;
  logic       ack = 1'b0;
  logic [1:0] arx;
  logic       ecx, wrx, astb, rd, wr, done, err;
  logic [3:0] word_idx;

  bus_sequencer #(.T_ASTB(TA), .T_XFER(TX), .TIMEOUT(TO), .BURST_LEN(BL)) dut (
    .clk      (clk),
    .reset    (reset),
    .request  (request),
    .ack      (ack),
    .arx      (arx),
    .ecx      (ecx),
    .wrx      (wrx),
    .astb     (astb),
    .rd       (rd),
    .wr       (wr),
    .done     (done),
    .err      (err),
    .word_idx (word_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [3:0] addr;
    logic [4:0] nph;
    logic [4:0] gaps;
    logic       astbx;
  } hdr_t;

  typedef struct packed {
    logic       rdk;
    logic [7:0] len;
    logic [3:0] widx;
  } ph_t;

  hdr_t hdr_q[$];
  ph_t  ph_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] outs();
    return {arx, ecx, wrx, astb, rd, wr, done, err, word_idx};
  endfunction

  function automatic bit is_rd_code(input int c);
    return c == 1 || c == 3 || c == 8 || c == 9 || c == 13 || c == 15;
  endfunction

  // One transaction: predict, queue expectations, drive request and ack.
  task automatic run_txn(input int code, input int fixed_d, input bit chg);
    int   dly[16];
    hdr_t h;
    ph_t  p;
    int   n, eff, sumlen, lat, ph, c, cyc, hold;
    bit   inph, got;
    for (int k = 0; k < 16; k++) begin
      if (fixed_d >= 0) dly[k] = fixed_d;
      else begin
        int r;
        r = int'($urandom_range(0, 11));
        dly[k] = (r == 11) ? 255 : (r == 10) ? TO - 1 : int'($urandom_range(0, 3));
      end
    end
    h = '0;
    n = (code >= 5 && code <= 7) ? 0 : (code == 12 || code == 13) ? BL : (code == 11) ? 2 : 1;
    h.err  = (n == 0);
    h.addr = (n == 0) ? 4'd0 : 4'(TA);
    sumlen = 0;
    for (int k = 0; k < n; k++) begin
      eff    = (dly[k] > TX - 1) ? dly[k] : TX - 1;
      p.rdk  = (code == 11) ? (k == 0) : is_rd_code(code);
      p.widx = (code == 12 || code == 13) ? 4'(k) : 4'd0;
      if (eff <= TO - 1) p.len = 8'(eff + 1);
      else begin
        p.len = 8'(TO);
        h.err = 1'b1;
      end
      ph_q.push_back(p);
      h.nph  = h.nph + 5'd1;
      sumlen += int'(p.len);
      if (h.err) break;
    end
    h.gaps  = (h.nph == 5'd0) ? 5'd0 : h.nph - 5'd1;
    h.astbx = (code == 11 || code == 12 || code == 13);
    lat     = (n == 0) ? 1 : TA + sumlen + int'(h.gaps) + 1;
    hdr_q.push_back(h);

    request = 4'(code);
    ack  = 1'b0;
    ph   = -1;
    c    = 0;
    cyc  = 0;
    inph = 1'b0;
    got  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (rd || wr) begin
        if (!inph) begin
          inph = 1'b1;
          if (ph < 15) ph++;
          c = 0;
          if (chg && ph == 0) request = 4'($urandom_range(1, 15));
        end else c++;
        ack = (c >= dly[ph]);
      end else begin
        inph = 1'b0;
        ack  = 1'b0;
      end
    end
    ack = 1'b0;
    chk("latency", got ? cyc : -1, lat);
    if (got) begin
      hold = int'($urandom_range(0, 2));
      repeat (hold) @(negedge clk);
      chk("done_hold", int'({done, err}), int'({1'b1, h.err}));
    end
    request = 4'd0;
    @(negedge clk);
    chk("release", int'(outs()), int'(IDLE_V));
  endtask

  // Monitor state
  ph_t  obs[$];
  ph_t  cur;
  bit   in_run, sigbad, astb_lo, astb_hi, pdone;
  int   n_addr, n_gap;

  task automatic mon_clear();
    obs.delete();
    in_run  = 1'b0;
    sigbad  = 1'b0;
    astb_lo = 1'b0;
    astb_hi = 1'b0;
    n_addr  = 0;
    n_gap   = 0;
  endtask

  // Monitor: rebuild phases every cycle, compare against the scoreboard on done.
  initial begin
    hdr_t h;
    ph_t  e;
    mon_clear();
    pdone = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mon_clear();
      end else if (done && !pdone) begin
        if (in_run) begin
          obs.push_back(cur);
          in_run = 1'b0;
        end
        chk("exp_avail", hdr_q.size(), 1);
        if (hdr_q.size() > 0) begin
          h = hdr_q.pop_front();
          chk("err", int'(err), int'(h.err));
          chk("addr_cycles", n_addr, int'(h.addr));
          chk("phases", obs.size(), int'(h.nph));
          chk("gaps", n_gap, int'(h.gaps));
          chk("strobe_sig", int'(sigbad), 0);
          chk("astb_xfer", int'(h.astbx ? astb_lo : astb_hi), 0);
          chk("done_outs", int'({arx, ecx, wrx, astb, rd, wr}), int'({2'b11, 5'd0}));
          for (int k = 0; k < int'(h.nph); k++) begin
            if (ph_q.size() > 0) begin
              e = ph_q.pop_front();
              if (k < obs.size()) begin
                chk("ph_kind", int'(obs[k].rdk), int'(e.rdk));
                chk("ph_len", int'(obs[k].len), int'(e.len));
                chk("ph_widx", int'(obs[k].widx), int'(e.widx));
              end
            end
          end
        end
        mon_clear();
      end else if (!done) begin
        if (rd || wr) begin
          if (!in_run) begin
            in_run   = 1'b1;
            cur.rdk  = rd;
            cur.len  = 8'd1;
            cur.widx = word_idx;
          end else cur.len = cur.len + 8'd1;
          if ((rd && wr) || (wrx != rd) || arx != 2'b01 || !ecx) sigbad = 1'b1;
          if (astb) astb_hi = 1'b1;
          else astb_lo = 1'b1;
        end else begin
          if (in_run) begin
            obs.push_back(cur);
            in_run = 1'b0;
          end
          if (astb && ecx && arx == 2'b00) n_addr++;
          else if (astb && !ecx && arx == 2'b11) n_gap++;
        end
      end
      pdone = done;
    end
  end

  // Stimulus
  initial begin
    int got;
    reset   = 1'b1;
    request = 4'd9;
    repeat (3) @(negedge clk);
    chk("reset_vals", int'(outs()), int'(IDLE_V));
    request = 4'd0;
    reset   = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    run_txn(9, 2, 1'b0);
    run_txn(10, 0, 1'b0);
    run_txn(11, 1, 1'b0);
    run_txn(13, 1, 1'b0);
    run_txn(12, -1, 1'b0);
    run_txn(8, 255, 1'b0);
    run_txn(6, 0, 1'b0);
    run_txn(1, TO - 1, 1'b0);
    run_txn(3, TO, 1'b0);
    run_txn(2, 3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      int code;
      code = int'($urandom_range(1, 15));
      run_txn(code, -1, ($urandom_range(0, 3) == 0));
    end

    // Abort during a read data phase.
    mon_en = 1'b0;
    @(negedge clk);
    request = 4'd9;
    ack = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd) begin
        got = 1;
        break;
      end
    end
    chk("abort_reach_xfer", got, 1);
    @(negedge clk);
    request = 4'd0;
    @(negedge clk);
    chk("abort_idle", int'(outs()), int'(IDLE_V));
    got = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("abort_no_done", got, 0);

    // Reset in the middle of a burst, with the request still asserted.
    request = 4'd13;
    ack = 1'b1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (word_idx == 4'd2 && rd) begin
        got = 1;
        break;
      end
    end
    chk("burst_reach_w2", got, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_burst", int'(outs()), int'(IDLE_V));
    reset   = 1'b0;
    request = 4'd0;
    ack     = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", int'(outs()), int'(IDLE_V));
    mon_en = 1'b1;

    repeat (2) @(negedge clk);
    chk("queue_empty", hdr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
